// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and helpers
// used by the result buffer and its storage.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [3:0] SLL  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] AND  = 4'd2;
  localparam logic [3:0] SRA  = 4'd3;
  localparam logic [3:0] SEQ  = 4'd4;
  localparam logic [3:0] SRL  = 4'd5;
  localparam logic [3:0] XNOR = 4'd6;
  localparam logic [3:0] XOR  = 4'd7;
  localparam logic [3:0] MIN  = 4'd8;
  localparam logic [3:0] SLTU = 4'd9;

  localparam logic [3:0] OPCODE_MAX = SLTU;

  localparam int ZF  = 0;
  localparam int CF  = 1;
  localparam int OVF = 2;

  localparam int OPCODE_W = 4;
  localparam int FLAGS_W  = 3;

  // Anything above the last defined encoding is treated as an illegal opcode.
  function automatic logic isIllegalOpcode(input logic [3:0] opcode);
    return (opcode > OPCODE_MAX);
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Circular storage for buffered ALU entries. Pushes into a full buffer and
// pops from an empty one are ignored here so the caller cannot corrupt state.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_WIDTH + OPCODE_W + FLAGS_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wrData,
  output logic [DATA_W-1:0]        rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic              doPush;
  logic              doPop;

  // Qualify requests against occupancy and derive the status flags.
  always_comb begin
    full   = (count == CNT_W'(DEPTH));
    empty  = (count == '0);
    doPush = push & ~full;
    doPop  = pop & ~empty;
    rdData = empty ? '0 : mem[rdPtr];
  end

  // Pointers and occupancy; reset discards contents by emptying the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= (wrPtr == PTR_W'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= (rdPtr == PTR_W'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array is left out of reset; stale data is never visible when empty.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= wrData;
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Buffers ALU results between the execute stage and its consumer, while
// tracking accumulated flags, sanity errors and a running accept count.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_opcode,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_carry,
  input  logic                     in_zero,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_opcode,
  output logic [WIDTH-1:0]         out_result,
  output logic [2:0]               out_flags,
  output logic [2:0]               sticky_flags,
  input  logic                     sticky_clear,
  output logic [1:0]               err_flags,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               accept_count
);

  localparam int ENTRY_W = OPCODE_W + FLAGS_W + WIDTH;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [2:0]         inFlags;
  logic [1:0]         newErr;
  logic [ENTRY_W-1:0] wrEntry;
  logic [ENTRY_W-1:0] rdEntry;

  // Handshakes depend only on occupancy; the entry is packed as opcode/flags/result.
  always_comb begin
    in_ready          = ~full;
    out_valid         = ~empty;
    push              = in_valid & in_ready;
    pop               = out_valid & out_ready;
    inFlags           = '0;
    inFlags[ZF]       = in_zero;
    inFlags[CF]       = in_carry;
    inFlags[OVF]      = in_overflow;
    newErr            = {isIllegalOpcode(in_opcode), (in_zero != (in_result == '0))};
    wrEntry           = {in_opcode, inFlags, in_result};
    {out_opcode, out_flags, out_result} = rdEntry;
  end

  alu_result_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wrData (wrEntry),
    .rdData (rdEntry),
    .count  (level),
    .full   (full),
    .empty  (empty)
  );

  // Sticky flags, errors and count; a push alongside a clear keeps only the new bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
      err_flags    <= '0;
      accept_count <= '0;
    end else begin
      if (push) begin
        sticky_flags <= (sticky_clear ? 3'b000 : sticky_flags) | inFlags;
        err_flags    <= (sticky_clear ? 2'b00 : err_flags) | newErr;
        accept_count <= accept_count + 8'd1;
      end else if (sticky_clear) begin
        sticky_flags <= '0;
        err_flags    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed self-checking bench for alu_result_buffer with hand-computed
// expectations for handshake, ordering, flag tracking and reset behaviour.
module tb_alu_result_buffer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [7:0] in_result;
  logic       in_carry;
  logic       in_zero;
  logic       in_overflow;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_opcode;
  logic [7:0] out_result;
  logic [2:0] out_flags;
  logic [2:0] sticky_flags;
  logic       sticky_clear;
  logic [1:0] err_flags;
  logic [2:0] level;
  logic [7:0] accept_count;

  int vectors;
  int miscompares;

  alu_result_buffer #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_zero      (in_zero),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .sticky_clear (sticky_clear),
    .err_flags    (err_flags),
    .level        (level),
    .accept_count (accept_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs (flags given as {overflow, carry, zero}), then sample point.
  task automatic applyStimulus(input logic valid, input logic [3:0] op, input logic [7:0] res,
                               input logic [2:0] flags, input logic outReady, input logic clear);
    in_valid     = valid;
    in_opcode    = op;
    in_result    = res;
    {in_overflow, in_carry, in_zero} = flags;
    out_ready    = outReady;
    sticky_clear = clear;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    sticky_clear = 1'b0;
  endtask

  // Compare one observed value against its expectation and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_opcode    = 4'd0;
    in_result    = 8'd0;
    in_carry     = 1'b0;
    in_zero      = 1'b0;
    in_overflow  = 1'b0;
    out_ready    = 1'b0;
    sticky_clear = 1'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_level", 32'(level), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    checkOutput("rst_accept", 32'(accept_count), 0);
    checkOutput("rst_sticky", 32'(sticky_flags), 0);
    checkOutput("rst_err", 32'(err_flags), 0);
    checkOutput("rst_out_result", 32'(out_result), 0);
    rst = 1'b0;
    checkOutput("post_rst_in_ready", 32'(in_ready), 1);

    // Single push then drain
    applyStimulus(1'b1, 4'd1, 8'h00, 3'b011, 1'b1, 1'b0);
    checkOutput("single_out_valid", 32'(out_valid), 1);
    checkOutput("single_out_result", 32'(out_result), 32'h00);
    checkOutput("single_out_flags", 32'(out_flags), 32'h3);
    checkOutput("single_out_opcode", 32'(out_opcode), 1);
    checkOutput("single_sticky", 32'(sticky_flags), 32'h3);
    checkOutput("single_err", 32'(err_flags), 0);
    checkOutput("single_accept", 32'(accept_count), 1);
    applyStimulus(1'b0, 4'd0, 8'h00, 3'b000, 1'b1, 1'b0);
    checkOutput("single_level_after", 32'(level), 0);
    checkOutput("single_out_valid_after", 32'(out_valid), 0);
    checkOutput("single_flags_empty", 32'(out_flags), 0);
    applyStimulus(1'b0, 4'd0, 8'h00, 3'b000, 1'b1, 1'b1);
    checkOutput("clear_sticky", 32'(sticky_flags), 0);

    // Fill to capacity with downstream stalled
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'd2, 8'(8'h10 + i), 3'b000, 1'b0, 1'b0);
      checkOutput($sformatf("fill_level_%0d", i), 32'(level), (i < 4) ? i + 1 : 4);
      checkOutput($sformatf("fill_in_ready_%0d", i), 32'(in_ready), (i >= 3) ? 0 : 1);
    end
    checkOutput("fill_accept", 32'(accept_count), 5);

    // Full with pop in same cycle must not push
    checkOutput("drain_head_0", 32'(out_result), 32'h10);
    applyStimulus(1'b1, 4'd2, 8'h99, 3'b000, 1'b1, 1'b0);
    checkOutput("full_no_push_level", 32'(level), 3);
    checkOutput("full_no_push_accept", 32'(accept_count), 5);
    for (int k = 1; k < 4; k++) begin
      checkOutput($sformatf("drain_head_%0d", k), 32'(out_result), 32'h10 + k);
      applyStimulus(1'b0, 4'd0, 8'h00, 3'b000, 1'b1, 1'b0);
    end
    checkOutput("drain_level", 32'(level), 0);
    checkOutput("drain_out_valid", 32'(out_valid), 0);
    checkOutput("drain_out_result_zero", 32'(out_result), 0);

    // Error detection and clear/set priority
    applyStimulus(1'b1, 4'd2, 8'h05, 3'b001, 1'b0, 1'b0);
    checkOutput("err_zero_mismatch", 32'(err_flags), 32'h1);
    checkOutput("err_sticky_a", 32'(sticky_flags), 32'h1);
    applyStimulus(1'b1, 4'd12, 8'h03, 3'b000, 1'b0, 1'b0);
    checkOutput("err_illegal", 32'(err_flags), 32'h3);
    applyStimulus(1'b1, 4'd3, 8'h07, 3'b110, 1'b0, 1'b1);
    checkOutput("clear_push_sticky", 32'(sticky_flags), 32'h6);
    checkOutput("clear_push_err", 32'(err_flags), 0);
    applyStimulus(1'b1, 4'd15, 8'h00, 3'b000, 1'b0, 1'b1);
    checkOutput("clear_push_err_set_wins", 32'(err_flags), 32'h3);
    checkOutput("clear_push_sticky_zero", 32'(sticky_flags), 0);
    checkOutput("err_level", 32'(level), 4);
    applyStimulus(1'b0, 4'd0, 8'h00, 3'b000, 1'b0, 1'b1);
    checkOutput("clear_err", 32'(err_flags), 0);
    checkOutput("err_entry0_op", 32'(out_opcode), 2);
    checkOutput("err_entry0_res", 32'(out_result), 32'h05);
    checkOutput("err_entry0_flags", 32'(out_flags), 32'h1);
    applyStimulus(1'b0, 4'd0, 8'h00, 3'b000, 1'b1, 1'b0);
    checkOutput("err_entry1_op", 32'(out_opcode), 12);
    checkOutput("err_entry1_res", 32'(out_result), 32'h03);
    applyStimulus(1'b0, 4'd0, 8'h00, 3'b000, 1'b1, 1'b0);
    checkOutput("err_entry2_op", 32'(out_opcode), 3);
    checkOutput("err_entry2_flags", 32'(out_flags), 32'h6);
    applyStimulus(1'b0, 4'd0, 8'h00, 3'b000, 1'b1, 1'b0);
    checkOutput("err_entry3_op", 32'(out_opcode), 15);
    applyStimulus(1'b0, 4'd0, 8'h00, 3'b000, 1'b1, 1'b0);
    checkOutput("err_drain_level", 32'(level), 0);
    checkOutput("err_accept", 32'(accept_count), 9);

    // Steady push and pop at level 2 across pointer wrap
    applyStimulus(1'b1, 4'd7, 8'h20, 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd7, 8'h21, 3'b000, 1'b0, 1'b0);
    checkOutput("stream_level_start", 32'(level), 2);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("stream_head_%0d", i), 32'(out_result), 32'h20 + i);
      applyStimulus(1'b1, 4'd7, 8'(8'h22 + i), 3'b000, 1'b1, 1'b0);
      checkOutput($sformatf("stream_level_%0d", i), 32'(level), 2);
    end
    checkOutput("stream_tail_0", 32'(out_result), 32'h2A);
    applyStimulus(1'b0, 4'd0, 8'h00, 3'b000, 1'b1, 1'b0);
    checkOutput("stream_tail_1", 32'(out_result), 32'h2B);
    applyStimulus(1'b0, 4'd0, 8'h00, 3'b000, 1'b1, 1'b0);
    checkOutput("stream_level_end", 32'(level), 0);
    checkOutput("stream_accept", 32'(accept_count), 21);

    // Counter wrap after 256 pushes from a fresh reset
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("wrap_accept_start", 32'(accept_count), 0);
    for (int i = 0; i < 255; i++) begin
      applyStimulus(1'b1, 4'd0, 8'(i + 1), 3'b000, 1'b1, 1'b0);
    end
    checkOutput("wrap_accept_255", 32'(accept_count), 255);
    applyStimulus(1'b1, 4'd0, 8'h01, 3'b000, 1'b1, 1'b0);
    checkOutput("wrap_accept_0", 32'(accept_count), 0);
    checkOutput("wrap_level", 32'(level), 1);
    applyStimulus(1'b0, 4'd0, 8'h00, 3'b000, 1'b1, 1'b0);
    checkOutput("wrap_level_drained", 32'(level), 0);

    // Asynchronous reset mid-operation at level 3
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'd8, 8'(8'h40 + i), 3'b000, 1'b0, 1'b0);
    end
    checkOutput("midrst_level_before", 32'(level), 3);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_level", 32'(level), 0);
    checkOutput("midrst_out_valid", 32'(out_valid), 0);
    checkOutput("midrst_in_ready", 32'(in_ready), 1);
    checkOutput("midrst_accept", 32'(accept_count), 0);
    checkOutput("midrst_out_result", 32'(out_result), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_level_after", 32'(level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter WIDTH, default 8: result/data width in bits.
REQ-002 Parameter DEPTH, default 4: buffer entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream ALU result is present this cycle.
REQ-006 in_ready  output  1  buffer can accept; equals not-full.
REQ-007 in_opcode  input  4  opcode that produced the result.
REQ-008 in_result  input  WIDTH  ALU result.
REQ-009 in_carry, in_zero, in_overflow  input  1 each  ALU flags.
REQ-010 out_valid  output  1  head entry available; equals not-empty.
REQ-011 out_ready  input  1  downstream consumes head this cycle.
REQ-012 out_opcode  output  4  head entry opcode.
REQ-013 out_result  output  WIDTH  head entry result.
REQ-014 out_flags  output  3  head entry flags {overflow, carry, zero}.
REQ-015 sticky_flags  output  3  OR of all accepted flags since last clear, same order.
REQ-016 sticky_clear  input  1  clears sticky_flags and err_flags.
REQ-017 err_flags  output  2  sticky {illegal_opcode, zero_mismatch}.
REQ-018 level  output  $clog2(DEPTH)+1  current occupancy.
REQ-019 accept_count  output  8  number of accepted results, modulo 256.

Function
REQ-020 Push SHALL occur when in_valid and in_ready are both high; pop when out_valid and out_ready are both high.
REQ-021 Entries SHALL leave in arrival order; a pushed entry SHALL appear at the outputs the cycle after the push when the buffer was empty (latency 1, no combinational pass-through).
REQ-022 in_ready SHALL depend only on occupancy, never combinationally on out_ready.
REQ-023 Full: in_ready low, no push even if out_ready is high that cycle; in_valid data is ignored.
REQ-024 Empty: out_valid low, out_opcode/out_result/out_flags held at 0, out_ready ignored.
REQ-025 Simultaneous push and pop when neither full nor empty: level unchanged, both pointers advance.
REQ-026 Read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-027 On each push, sticky_flags SHALL OR in the incoming flags; sticky_clear in the same cycle as a push SHALL leave sticky_flags equal to the incoming flags only.
REQ-028 zero_mismatch SHALL set on a push where in_zero differs from (in_result == 0); the entry is still stored unmodified.
REQ-029 illegal_opcode SHALL set on a push with in_opcode greater than 9; the entry is still stored.
REQ-030 err_flags SHALL obey the same clear-versus-set priority as REQ-027 (set wins).
REQ-031 accept_count SHALL increment by 1 per push and wrap 255 -> 0.

Reset
REQ-032 While rst is high: level, accept_count, sticky_flags, err_flags, out_valid, out_opcode, out_result, out_flags = 0; pointers = 0.
REQ-033 in_ready SHALL be high during and after reset, since the buffer is empty.
REQ-034 Reset mid-operation SHALL discard all stored entries; storage contents need not be cleared.

Structure
REQ-035 Shared package alu_pkg SHALL hold: opcode constants SLL=0, SUB=1, AND=2, SRA=3, SEQ=4, SRL=5, XNOR=6, XOR=7, MIN=8, SLTU=9; OPCODE_MAX=9; flag bit indices ZF=0, CF=1, OVF=2; default WIDTH=8.
REQ-036 Storage and pointers SHALL be a sub-module alu_result_fifo; flag and error tracking and counters stay in alu_result_buffer.

Verification
REQ-037 Single push {opcode=1, result=0x00, zero=1, carry=1} with out_ready=1 -> out_valid high the next cycle with out_result=0x00 and out_flags=3'b011; sticky_flags=3'b011; level returns to 0.
REQ-038 Five pushes with out_ready=0 -> the first four are accepted, in_ready falls after the 4th, the 5th is not stored, level=4; draining yields the 4 results in order.
REQ-039 Push {result=0x05, zero=1} -> err_flags[0]=1; push {opcode=12} -> err_flags[1]=1; sticky_clear -> both 0.
REQ-040 Level 2, push and pop every cycle for 10 cycles -> level stays 2, data order is preserved across pointer wrap.
REQ-041 256 pushes -> accept_count=0; assert rst while level=3 -> level=0, out_valid=0, in_ready=1 immediately.
